instr_cache_ctrl: RTL and testbench

// - Direct-mapped, read-only instruction cache and refill controller. Sits directly upstream of the main control FSM.
// - Main FSM drives its start-i-cache output into i_start and consumes o_stall as its instruction-stall input.
// - Hit: instruction is returned combinationally in the same cycle. Miss: whole line is fetched from memory over a valid-handshake beat interface.

---
 rtl/instr_cache_ctrl.sv | 138 +++++++++++++
 tb/tb_instr_cache_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_ctrl.sv
// Direct-mapped read-only instruction cache with a single-line refill FSM.
// Optional flush support (i_flush, sticky flush during refill) is enabled by ICACHE_FLUSH_EN.
module instr_cache_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ICACHE_FLUSH_EN
  input  logic                  i_flush,
`endif
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [31:0]           o_instr,
  output logic                  o_stall,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_valid,
  input  logic [31:0]           i_mem_data
);

  // state    | meaning
  // S_IDLE   | lookup; hit returns instruction, miss latches line address
  // S_REFILL | request line from memory, write beats, install on last beat

  localparam int OFF   = $clog2(LINE_WORDS * 4);
  localparam int IDX   = $clog2(SETS);
  localparam int WB    = $clog2(LINE_WORDS);
  localparam int LINEW = ADDR_WIDTH - OFF;
  localparam int TAGW  = LINEW - IDX;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_IDLE = 1'b0, S_REFILL = 1'b1} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]  valid_q;
  logic [TAGW-1:0]  tag_arr  [SETS];
  logic [31:0]      data_arr [SETS][LINE_WORDS];
  logic [LINEW-1:0] miss_line;
  logic [WB-1:0]    beat_cnt;

  logic [WB-1:0]   word_sel;
  logic [IDX-1:0]  idx;
  logic [TAGW-1:0] tag;
  logic [IDX-1:0]  miss_idx;
  logic [TAGW-1:0] miss_tag;
  logic            hit;
  logic            beat_we;
  logic            last_beat;
  logic            miss_start;
  logic            flush_idle;
  logic            flush_line;
  logic            unused_addr_lsb;

  assign word_sel        = i_addr[OFF-1:2];
  assign idx             = i_addr[OFF+IDX-1:OFF];
  assign tag             = i_addr[ADDR_WIDTH-1:OFF+IDX];
  assign miss_idx        = miss_line[IDX-1:0];
  assign miss_tag        = miss_line[LINEW-1:IDX];
  assign unused_addr_lsb = ^i_addr[1:0];

  assign hit        = valid_q[idx] && (tag_arr[idx] == tag);
  assign beat_we    = (state_q == S_REFILL) && i_mem_valid;
  assign last_beat  = beat_we && (beat_cnt == WB'(LINE_WORDS - 1));
  assign miss_start = (state_q == S_IDLE) && i_start && !hit && !flush_idle;

`ifdef ICACHE_FLUSH_EN
  logic flush_pend;

  // A flush seen mid-refill must still suppress installation of that line.
  always_ff @(posedge clk) begin
    if (rst)                                   flush_pend <= 1'b0;
    else if (last_beat)                        flush_pend <= 1'b0;
    else if ((state_q == S_REFILL) && i_flush) flush_pend <= 1'b1;
  end

  assign flush_idle = i_flush && (state_q == S_IDLE);
  assign flush_line = flush_pend || i_flush;
`else
  assign flush_idle = 1'b0;
  assign flush_line = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    o_stall    = i_start;
    o_mem_req  = 1'b0;
    o_mem_addr = '0;
    o_instr    = hit ? data_arr[idx][word_sel] : NOP;
    unique case (state_q)
      S_IDLE: begin
        if (hit && !flush_idle) o_stall = 1'b0;
        if (miss_start)         state_d = S_REFILL;
      end
      S_REFILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {miss_line, {OFF{1'b0}}};
        if (last_beat) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      beat_cnt  <= '0;
      miss_line <= '0;
    end else begin
      if (miss_start) miss_line <= i_addr[ADDR_WIDTH-1:OFF];
      if (flush_idle) valid_q <= '0;
      if (beat_we) begin
        if (last_beat) begin
          beat_cnt <= '0;
          if (flush_line) valid_q <= '0;
          else            valid_q[miss_idx] <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (beat_we && !rst) begin
      data_arr[miss_idx][beat_cnt] <= i_mem_data;
      if (last_beat) tag_arr[miss_idx] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Directed bench for instr_cache_ctrl: cold miss, hit, conflict, gapped beats, reset mid-refill.
module tb_instr_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [63:0] i_addr;
  logic [31:0] o_instr;
  logic        o_stall;
  logic        o_mem_req;
  logic [63:0] o_mem_addr;
  logic        i_mem_valid;
  logic [31:0] i_mem_data;
`ifdef ICACHE_FLUSH_EN
  logic        i_flush;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  instr_cache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ICACHE_FLUSH_EN
    .i_flush     (i_flush),
`endif
    .i_start     (i_start),
    .i_addr      (i_addr),
    .o_instr     (o_instr),
    .o_stall     (o_stall),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_valid (i_mem_valid),
    .i_mem_data  (i_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d);
    i_mem_valid = v;
    i_mem_data  = d;
    tick();
    i_mem_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_addr = '0; i_mem_valid = 1'b0; i_mem_data = '0;
`ifdef ICACHE_FLUSH_EN
    i_flush = 1'b0;
`endif
    tick(); tick();
    #1;
    chk("rst_stall_idle", 64'(o_stall), 64'd0);
    chk("rst_mem_req", 64'(o_mem_req), 64'd0);
    chk("rst_mem_addr", o_mem_addr, 64'h0);
    i_start = 1'b1; i_addr = 64'h80;
    #1;
    chk("rst_stall_start", 64'(o_stall), 64'd1);
    tick();

    // cold miss on 0x80
    rst = 1'b0;
    #1;
    chk("cold_miss_stall", 64'(o_stall), 64'd1);
    chk("cold_idle_req", 64'(o_mem_req), 64'd0);
    tick();
    #1;
    chk("cold_req", 64'(o_mem_req), 64'd1);
    chk("cold_addr", o_mem_addr, 64'h80);
    beat(1'b1, 32'd11); beat(1'b1, 32'd22); beat(1'b1, 32'd33);
    #1;
    chk("cold_stall_b3", 64'(o_stall), 64'd1);
    beat(1'b1, 32'd44);
    #1;
    chk("cold_done_stall", 64'(o_stall), 64'd0);
    chk("cold_instr", 64'(o_instr), 64'd11);
    chk("cold_req_drop", 64'(o_mem_req), 64'd0);

    // hits in the filled line
    i_addr = 64'h8C;
    #1;
    chk("hit_stall", 64'(o_stall), 64'd0);
    chk("hit_instr", 64'(o_instr), 64'd44);
    chk("hit_req", 64'(o_mem_req), 64'd0);
    i_addr = 64'h84;
    #1;
    chk("hit_instr_w1", 64'(o_instr), 64'd22);
    tick();
    #1;
    chk("hit_no_refill", 64'(o_mem_req), 64'd0);

    // conflict at index 8, with i_addr wandering during refill
    i_addr = 64'h180;
    #1;
    chk("conf_stall", 64'(o_stall), 64'd1);
    tick();
    #1;
    chk("conf_req", 64'(o_mem_req), 64'd1);
    chk("conf_addr", o_mem_addr, 64'h180);
    beat(1'b1, 32'h55);
    i_addr = 64'h344;
    #1;
    chk("conf_addr_hold", o_mem_addr, 64'h180);
    beat(1'b1, 32'h66); beat(1'b1, 32'h77);
    i_addr = 64'h180;
    beat(1'b1, 32'h88);
    #1;
    chk("conf_stall_done", 64'(o_stall), 64'd0);
    chk("conf_instr", 64'(o_instr), 64'h55);
    i_addr = 64'h80;
    #1;
    chk("conf_evict_stall", 64'(o_stall), 64'd1);

    // gapped beats 1,0,0,1,1,0,1 on refill of 0x80
    tick();
    #1;
    chk("gap_addr", o_mem_addr, 64'h80);
    beat(1'b1, 32'hA1); beat(1'b0, 32'hDEAD); beat(1'b0, 32'hDEAD);
    beat(1'b1, 32'hA2); beat(1'b1, 32'hA3);
    #1;
    chk("gap_req_pre", 64'(o_mem_req), 64'd1);
    chk("gap_stall_pre", 64'(o_stall), 64'd1);
    beat(1'b0, 32'hDEAD);
    beat(1'b1, 32'hA4);
    #1;
    chk("gap_req_drop", 64'(o_mem_req), 64'd0);
    chk("gap_stall", 64'(o_stall), 64'd0);
    chk("gap_w0", 64'(o_instr), 64'hA1);
    i_addr = 64'h84; #1; chk("gap_w1", 64'(o_instr), 64'hA2);
    i_addr = 64'h88; #1; chk("gap_w2", 64'(o_instr), 64'hA3);
    i_addr = 64'h8C; #1; chk("gap_w3", 64'(o_instr), 64'hA4);

    // beats outside refill are ignored
    i_start = 1'b0; i_addr = 64'h80; i_mem_valid = 1'b1; i_mem_data = 32'hBAD0_BAD0;
    tick();
    i_mem_valid = 1'b0; i_start = 1'b1;
    #1;
    chk("idle_beat_instr", 64'(o_instr), 64'hA1);
    chk("idle_beat_req", 64'(o_mem_req), 64'd0);
    chk("stall_no_start", 64'(o_stall), 64'd0);

    // i_start dropped mid-refill still installs the line
    i_addr = 64'h100;
    #1;
    chk("drop_miss", 64'(o_stall), 64'd1);
    tick();
    i_start = 1'b0;
    #1;
    chk("drop_stall_low", 64'(o_stall), 64'd0);
    chk("drop_req", 64'(o_mem_req), 64'd1);
    beat(1'b1, 32'hD1); beat(1'b1, 32'hD2); beat(1'b1, 32'hD3); beat(1'b1, 32'hD4);
    i_start = 1'b1;
    #1;
    chk("drop_hit_stall", 64'(o_stall), 64'd0);
    chk("drop_instr", 64'(o_instr), 64'hD1);

    // reset mid-refill aborts and leaves the line invalid
    i_addr = 64'h80;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rmr_cold_miss", 64'(o_stall), 64'd1);
    tick();
    #1;
    chk("rmr_req", 64'(o_mem_req), 64'd1);
    beat(1'b1, 32'h11); beat(1'b1, 32'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rmr_req_drop", 64'(o_mem_req), 64'd0);
    chk("rmr_stall", 64'(o_stall), 64'd1);
    tick();
    #1;
    chk("rmr_req2", 64'(o_mem_req), 64'd1);
    chk("rmr_addr2", o_mem_addr, 64'h80);
    beat(1'b1, 32'hC1); beat(1'b1, 32'hC2); beat(1'b1, 32'hC3); beat(1'b1, 32'hC4);
    #1;
    chk("rmr_stall_done", 64'(o_stall), 64'd0);
    chk("rmr_w0", 64'(o_instr), 64'hC1);
    i_addr = 64'h8C; #1; chk("rmr_w3", 64'(o_instr), 64'hC4);

`ifdef ICACHE_FLUSH_EN
    // flush in IDLE, then flush during refill
    i_addr = 64'h80; i_flush = 1'b1;
    #1;
    chk("fl_idle_stall", 64'(o_stall), 64'd1);
    tick();
    i_flush = 1'b0;
    #1;
    chk("fl_no_req", 64'(o_mem_req), 64'd0);
    chk("fl_miss", 64'(o_stall), 64'd1);
    tick();
    #1;
    chk("fl_req", 64'(o_mem_req), 64'd1);
    beat(1'b1, 32'hE1);
    i_flush = 1'b1;
    beat(1'b1, 32'hE2);
    i_flush = 1'b0;
    beat(1'b1, 32'hE3); beat(1'b1, 32'hE4);
    #1;
    chk("fl_pend_req_drop", 64'(o_mem_req), 64'd0);
    chk("fl_pend_invalid", 64'(o_stall), 64'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
